// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: pops PS/2 Set-2 scan codes from a FIFO, tracks the held key, counts presses and drives four 7-seg digits
module ps2_kbd_ctrl #(
    parameter int COUNT_W        = 8,
    parameter bit SEG_ACTIVE_LOW = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fifo_empty,
    input  logic [7:0]         fifo_rd_data,
    output logic               fifo_rd_en,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic               key_held,
    output logic               press_pulse,
    output logic               rel_pulse,
    output logic [COUNT_W-1:0] press_count,
    output logic [7:0]         seg0,
    output logic [7:0]         seg1,
    output logic [7:0]         seg2,
    output logic [7:0]         seg3
);
    typedef enum logic [1:0] {IDLE, READ, DECODE} state_t;
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [7:0] BLANK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    state_t             state_q, state_d;
    logic               ext_q, ext_d, brk_q, brk_d;
    logic [7:0]         key_code_q, key_code_d;
    logic               key_ext_q, key_ext_d, key_held_q, key_held_d;
    logic               press_q, press_d, rel_q, rel_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               same_key;
    logic [7:0]         cnt8;
    assign same_key = key_held_q && fifo_rd_data == key_code_q && ext_q == key_ext_q;
    // next-state: sequence IDLE/READ/DECODE and apply the Set-2 prefix/make/break rules in DECODE
    always_comb begin
        state_d    = state_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        key_code_d = key_code_q;
        key_ext_d  = key_ext_q;
        key_held_d = key_held_q;
        count_d    = count_q;
        press_d    = 1'b0;
        rel_d      = 1'b0;
        unique case (state_q)
            IDLE:    state_d = fifo_empty ? IDLE : READ;
            READ:    state_d = DECODE;
            DECODE: begin
                state_d = IDLE;
                if (fifo_rd_data == 8'hE0) ext_d = 1'b1;
                else if (fifo_rd_data == 8'hF0) brk_d = 1'b1;
                else begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    if (!brk_q && !same_key) begin
                        key_code_d = fifo_rd_data;
                        key_ext_d  = ext_q;
                        key_held_d = 1'b1;
                        count_d    = count_q + COUNT_W'(1);
                        press_d    = 1'b1;
                    end else if (brk_q && same_key) begin
                        key_code_d = 8'h00;
                        key_ext_d  = 1'b0;
                        key_held_d = 1'b0;
                        rel_d      = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state register, asynchronously cleared; a reset mid-read simply drops the pending byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            key_code_q <= 8'h00;
            key_ext_q  <= 1'b0;
            key_held_q <= 1'b0;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            key_code_q <= key_code_d;
            key_ext_q  <= key_ext_d;
            key_held_q <= key_held_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            count_q    <= count_d;
        end
    end
    assign cnt8        = 8'(count_q);
    assign fifo_rd_en  = state_q == READ;
    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign key_held    = key_held_q;
    assign press_pulse = press_q;
    assign rel_pulse   = rel_q;
    assign press_count = count_q;
    // glyph lookup with polarity; key digits blank while no key is held
    always_comb begin
        seg0 = !key_held_q ? BLANK : SEG_ACTIVE_LOW ? ~{1'b0, GLYPH[key_code_q[3:0]]} : {1'b0, GLYPH[key_code_q[3:0]]};
        seg1 = !key_held_q ? BLANK : SEG_ACTIVE_LOW ? ~{1'b0, GLYPH[key_code_q[7:4]]} : {1'b0, GLYPH[key_code_q[7:4]]};
        seg2 = SEG_ACTIVE_LOW ? ~{1'b0, GLYPH[cnt8[3:0]]} : {1'b0, GLYPH[cnt8[3:0]]};
        seg3 = SEG_ACTIVE_LOW ? ~{1'b0, GLYPH[cnt8[7:4]]} : {1'b0, GLYPH[cnt8[7:4]]};
    end
endmodule
